// File: rtl/gpc_pkg.sv
// rtl/gpc_pkg.sv - shared state encoding and GPC sizing constants for the popcount engine
package gpc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int GPC73_IN  = 7;
    localparam int GPC73_OUT = 3;

endpackage

// File: rtl/gpc7_3.sv
// rtl/gpc7_3.sv - combinational 7-input, 3-bit-output generalized parallel counter
module gpc7_3
    import gpc_pkg::*;
(
    input  logic [GPC73_IN-1:0]  bits,
    output logic [GPC73_OUT-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < GPC73_IN; i++) begin
            count = count + {{(GPC73_OUT-1){1'b0}}, bits[i]};
        end
    end

endmodule

// File: rtl/gpc_popcount_seq.sv
// rtl/gpc_popcount_seq.sv - sequential popcount that time-shares one gpc7_3 across a wide word
module gpc_popcount_seq
    import gpc_pkg::*;
#(
    parameter  int DATA_W = 63,
    localparam int SUM_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic              busy
);

    localparam int NCHUNK = (DATA_W + GPC73_IN - 1) / GPC73_IN;
    localparam int WORD_W = NCHUNK * GPC73_IN;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t               state;
    logic [WORD_W-1:0]    word;
    logic [IDX_W-1:0]     idx;
    logic [SUM_W-1:0]     acc;
    logic [GPC73_OUT-1:0] cnt;

    // The word shifts right each RUN cycle, so the counter always sees the low chunk.
    gpc7_3 u_gpc (
        .bits  (word[GPC73_IN-1:0]),
        .count (cnt)
    );

    assign out_sum = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            acc       <= '0;
            idx       <= '0;
            word      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word     <= WORD_W'(in_data);
                        acc      <= '0;
                        idx      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    word <= word >> GPC73_IN;
                    acc  <= acc + SUM_W'(cnt);
                    idx  <= idx + 1'b1;
                    if (idx == IDX_W'(NCHUNK - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/gpc_popcount_seq.md
Name: gpc_popcount_seq

Overview:
Sequential population-count engine that time-shares one gpc7_3 (7-input, 3-bit-output generalized parallel counter) over a wide input vector. It accepts a DATA_W-bit word over a valid/ready handshake and feeds it to the counter 7 bits per cycle. Chunk counts are accumulated and the total is returned over a second valid/ready handshake. It is the low-area alternative to a fully unrolled GPC compressor tree, for popcount or Hamming-weight paths that are not throughput-critical.

Parameters:
DATA_W, 63, input vector width in bits; legal values are 1 or greater.
NCHUNK (localparam), ceil(DATA_W/7), number of 7-bit chunks per word.
SUM_W (localparam), $clog2(DATA_W+1), result width.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data is presented
in_ready  output  1  block can accept a word
in_data  input  DATA_W  vector to count
out_valid  output  1  out_sum is valid
out_ready  input  1  consumer accepts out_sum
out_sum  output  SUM_W  number of 1 bits in the accepted word
busy  output  1  high in RUN or DONE

Behaviour:
- Reset:
  - clk is the only clock; rst is synchronous, active-high and overrides all other inputs.
  - After reset: state=IDLE, in_ready=1, out_valid=0, out_sum=0, busy=0, accumulator=0, chunk index=0.
- Internal word register:
  - Width NCHUNK*7.
  - Loaded with in_data zero-extended, so pad bits at and above DATA_W are 0.
- FSM with states IDLE, RUN, DONE:
  - IDLE: in_ready=1. On in_valid && in_ready, latch in_data, clear the accumulator and index, then go to RUN. Otherwise stay in IDLE.
  - RUN: in_ready=0. Each cycle, chunk[idx] (bits 7*idx+6 .. 7*idx) drives gpc7_3. Then acc <= acc + zero-extended 3-bit count, and idx <= idx+1. After the cycle with idx==NCHUNK-1, go to DONE. RUN lasts exactly NCHUNK cycles.
  - DONE: out_valid=1 and out_sum=acc, held stable until out_valid && out_ready. On that handshake, go to IDLE and drop out_valid. in_ready stays 0 in DONE, so a new word is taken no earlier than the cycle after the out handshake.
- Latency and throughput:
  - Input handshake at edge E puts the block in RUN at E; out_valid rises at edge E+NCHUNK.
  - With out_ready held at 1, a new input handshake happens at E+NCHUNK+2 at the earliest. Minimum period is NCHUNK+2 cycles per word.
- Arithmetic and width:
  - Accumulator is SUM_W bits and cannot overflow, since the sum is at most DATA_W.
  - The gpc7_3 output is the exact 3-bit sum of its 7 inputs (0..7).
- Boundary cases:
  - DATA_W<=7: NCHUNK=1, so RUN lasts one cycle.
  - DATA_W not a multiple of 7: the last chunk is partially zero-padded and the padding contributes 0.
  - in_valid outside IDLE is ignored; no data is captured.
  - out_ready while out_valid=0 has no effect.
  - out_sum keeps its last value after the handshake. Its content outside DONE is not specified beyond the reset value.
- Reset mid-operation: rst in RUN or DONE aborts the word, discards the partial sum, and gives the reset values on the next cycle. No out_valid pulse is produced for the aborted word.
- busy = (state != IDLE).

Decomposition:
- Shared package gpc_pkg holds:
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the constant GPC73_IN=7;
  - the constant GPC73_OUT=3.
- One sub-module: the existing combinational gpc7_3 (7-bit input, 3-bit output), instantiated once. No other hierarchy.
- Chunk selection is an indexed part-select on the word register; shifting the word register right by 7 per cycle is an acceptable equivalent.

Test Plan:
- DATA_W=63, in_data=all ones, out_ready=1 -> out_sum=63 (6'h3f). out_valid rises exactly 9 edges after the input handshake and stays high for 1 cycle.
- DATA_W=63, in_data=63'h5555_5555_5555_5555 (alternating, bit0=1) -> out_sum=32. Then in_data=0 -> out_sum=0.
- DATA_W=63, in_data=63'h1, out_ready held low for 5 cycles after out_valid -> out_valid and out_sum=1 stay stable for all 5 cycles, and in_ready=0 throughout. in_valid pulsed during this window is ignored; the block returns to IDLE one cycle after out_ready rises.
- Back-to-back: in_valid held high with words 63'h7F then 63'h3 -> results 7 then 2, in order. Input handshakes are 11 cycles apart with out_ready=1.
- Reset mid-RUN: accept an all-ones word, assert rst for 1 cycle at the 4th RUN cycle -> next cycle in_ready=1, out_valid=0, busy=0, with no out_valid for that word. The next word 63'hFF gives 8.
- DATA_W=10 (NCHUNK=2): in_data=10'h3FF -> out_sum=10 with 2-cycle RUN. in_data=10'h200 -> 1, which checks that padding bits do not leak into the count.
